// File: rtl/regfile_param.sv
// Parameterised 3-read/1-write register file that self-clears after reset, with an optional PC alias on the top register.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned PC_ALIAS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] RD3,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  input  logic              WE,
  input  logic [DATA_W-1:0] R15,
  output logic              ready
);

  localparam int unsigned      NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] TOP     = ADDR_W'(NREGS - 1);
  localparam bit               ALIAS_EN = (PC_ALIAS != 0);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] regs [NREGS];
  logic              run_ok;
  logic              wr_ok;

  // Reads and writes are only live in RUN with reset released.
  assign run_ok = (state == RUN) && !rst;
  assign wr_ok  = run_ok && WE && !(ALIAS_EN && (WA == TOP));

  // Clearing sweep, state and ready; stored contents are untouched on a reset edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
      cnt       <= cnt + ADDR_W'(1);
      if (cnt == TOP) begin
        state <= RUN;
        ready <= 1'b1;
      end
    end else if (wr_ok) begin
      regs[WA] <= WD;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v;
    v = '0;
    if (ALIAS_EN && (a == TOP)) begin
      v = R15;
    end else if (run_ok) begin
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && (a == WA)) v = WD;
      else                    v = regs[a];
`else
      v = regs[a];
`endif
    end
    return v;
  endfunction

  always_comb begin
    RD1 = rd_port(A1);
    RD2 = rd_port(A2);
    RD3 = rd_port(A3);
  end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; register count NREGS = 2**ADDR_W.
REQ-003 SHALL have parameter PC_ALIAS, default 1, which makes the top register (index NREGS-1) an alias of the PC input.
REQ-004 SHALL have port: clk  input  1  single clock, all state changes on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have ports: A1, A2, A3  input  ADDR_W  read addresses for ports 1..3.
REQ-007 SHALL have ports: RD1, RD2, RD3  output  DATA_W  read data for ports 1..3.
REQ-008 SHALL have port: WA  input  ADDR_W  write address.
REQ-009 SHALL have port: WD  input  DATA_W  write data.
REQ-010 SHALL have port: WE  input  1  write enable.
REQ-011 SHALL have port: R15  input  DATA_W  PC value (PC+8) returned for top-register reads when PC_ALIAS=1.
REQ-012 SHALL have port: ready  output  1  high when clearing is complete and the file accepts writes.

Function
REQ-013 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-014 In CLEAR, SHALL write zero to register[cnt] on each edge and increment cnt (ADDR_W bits); on the edge where cnt==NREGS-1, SHALL enter RUN.
REQ-015 ready SHALL be registered and equal (state==RUN); it rises on the NREGS-th edge after rst deasserts.
REQ-016 In CLEAR, SHALL ignore WE, and RD1..RD3 SHALL read 0.
REQ-017 In RUN, reads SHALL be combinational: RDx = register[Ax], subject to REQ-018 and REQ-020.
REQ-018 When PC_ALIAS=1 and Ax==NREGS-1, RDx SHALL equal R15 regardless of state and WE.
REQ-019 In RUN with WE=1, SHALL write WD to register[WA] on the rising edge; when PC_ALIAS=1 and WA==NREGS-1, the write SHALL be dropped.
REQ-020 All three read ports SHALL be independent; identical addresses on several ports SHALL return identical data.
REQ-021 With WE=0, register contents SHALL hold indefinitely.

Reset
REQ-022 rst=1 on an edge SHALL set state=CLEAR, cnt=0 and ready=0; register contents are not touched on that edge.
REQ-023 rst asserted mid-CLEAR SHALL restart clearing from index 0.
REQ-024 rst asserted in RUN SHALL re-clear the whole file; any write presented on the reset edge SHALL be dropped.
REQ-025 While rst=1, RD1..RD3 SHALL read 0, except for PC-alias reads (REQ-018).

Configuration
REQ-026 Macro REGFILE_BYPASS_EN, when defined: in RUN with WE=1 and Ax==WA (and not a dropped PC write), RDx SHALL return WD in the same cycle (write-to-read forwarding).
REQ-027 Without REGFILE_BYPASS_EN: RDx SHALL return the old stored value until the write edge, then the new value.

Verification
REQ-028 rst=1 for 1 cycle, then 0 (ADDR_W=4): ready=0 for edges 1..15 and 1 after edge 16; all RDx=0 throughout.
REQ-029 In RUN: WE=1, WA=3, WD=0xDEADBEEF, then WE=0 and A1=A2=A3=3: all RDx=0xDEADBEEF.
REQ-030 PC_ALIAS=1, R15=0x00000108: WE=1, WA=15, WD=0x5 for one cycle, then A1=15: RD1=0x00000108 (write dropped).
REQ-031 With REGFILE_BYPASS_EN, reg2=0x11: WE=1, WA=2, WD=0x22 and A2=2 before the edge: RD2=0x22 combinationally; without the macro RD2=0x11 until the edge, then 0x22.
REQ-032 Write reg5=0xAA, assert rst for 1 cycle at clear step 7, then run to ready: reg5=0, and ready rises exactly 16 edges after rst drops.
REQ-033 During CLEAR: WE=1, WA=4, WD=0x99: ignored; after ready, RD1 with A1=4 reads 0.
